// File: rtl/loader_pkg.sv
// Shared state type and constants for the UART boot loader.
// The checksum stage is present only when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_HDR = 3'd0,
    ST_LEN0     = 3'd1,
    ST_LEN1     = 3'd2,
    ST_DATA     = 3'd3,
    ST_WRITE    = 3'd4,
    ST_CSUM     = 3'd5,
    ST_DONE     = 3'd6,
    ST_ERROR    = 3'd7
  } state_e;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;
  localparam logic [2:0] OPTION_WORD = 3'b010;
  localparam int unsigned MIN_DIV = 16;

endpackage

// File: rtl/uart_boot_loader_rx.sv
// 8N1 receiver: 2-flop synchronizer, mid-bit sampling, byte strobe.
// Start edges are re-checked at half a bit to reject glitches.
module uart_rx #(
  parameter int unsigned DIV = 86
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic          s1_q, s2_q, prev_q;
  logic [1:0]    st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !s2_q) st_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {s2_q, shift_q[7:1]};
          if (bit_q == 3'd7) st_d = RX_STOP;
          else bit_d = bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          st_d    = RX_IDLE;
          valid_d = s2_q;
          ferr_d  = !s2_q;
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      prev_q  <= 1'b1;
      st_q    <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      s1_q    <= rx;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_byte    = shift_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_boot_loader.sv
// Serial boot loader: holds the Core while a framed image is written.
// Define LOADER_CHECKSUM_EN to require and verify the trailing CSUM byte.
module uart_boot_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 10_000_000,
  parameter int unsigned BAUD_RATE    = 115200,
  parameter int unsigned MEMORY_SIZE  = 1024,
  parameter logic [31:0] BASE_ADDRESS = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  input  logic        skip_load,
  output logic        mem_write,
  output logic [2:0]  mem_option,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        core_hold,
  output logic        busy,
  output logic        error
);

  localparam int unsigned DIV = CLK_FREQ / BAUD_RATE;

  if (DIV < MIN_DIV) begin : g_div_chk
    $error("uart_boot_loader: CLK_FREQ/BAUD_RATE must be at least 16");
  end

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       frame_err;

  uart_rx #(.DIV(DIV)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] wdata_q, wdata_d;
  logic        error_q, error_d;
  logic [31:0] nbytes;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  assign busy = state_q inside {ST_LEN0, ST_LEN1, ST_DATA, ST_WRITE, ST_CSUM};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    wdata_d = wdata_q;
    error_d = error_q;
    nbytes  = {14'd0, rx_byte, len_q[7:0], 2'b00};
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      ST_WAIT_HDR: begin
        if (skip_load) begin
          state_d = ST_DONE;
        end else if (byte_valid && rx_byte == HEADER_BYTE) begin
          state_d = ST_LEN0;
          error_d = 1'b0;
          idx_d   = '0;
          bcnt_d  = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      ST_LEN0: begin
        if (byte_valid) begin
          len_d[7:0] = rx_byte;
          state_d    = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (byte_valid) begin
          len_d[15:8] = rx_byte;
          if (nbytes > 32'(MEMORY_SIZE)) state_d = ST_ERROR;
`ifdef LOADER_CHECKSUM_EN
          else if (len_d == 16'd0) state_d = ST_CSUM;
`else
          else if (len_d == 16'd0) state_d = ST_DONE;
`endif
          else state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (byte_valid) begin
          wdata_d[8*bcnt_q +: 8] = rx_byte;
          bcnt_d = bcnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q + rx_byte;
`endif
          if (bcnt_q == 2'd3) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        idx_d = idx_q + 16'd1;
`ifdef LOADER_CHECKSUM_EN
        state_d = (idx_d == len_q) ? ST_CSUM : ST_DATA;
`else
        state_d = (idx_d == len_q) ? ST_DONE : ST_DATA;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (byte_valid) state_d = (rx_byte == csum_q) ? ST_DONE : ST_ERROR;
      end
`endif
      ST_DONE:  state_d = ST_DONE;
      ST_ERROR: state_d = ST_WAIT_HDR;
      default:  state_d = ST_WAIT_HDR;
    endcase
    // A bad stop bit mid-frame aborts the load; idle/done states drop it
    if (frame_err && busy) state_d = ST_ERROR;
    if (state_d == ST_ERROR) error_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT_HDR;
      len_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      wdata_q <= '0;
      error_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      wdata_q <= wdata_d;
      error_q <= error_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign mem_write      = (state_q == ST_WRITE);
  assign mem_option     = OPTION_WORD;
  assign mem_address    = BASE_ADDRESS + {14'd0, idx_q, 2'b00};
  assign mem_write_data = wdata_q;
  assign core_hold      = (state_q != ST_DONE);
  assign error          = error_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Randomized frame-level bench for uart_boot_loader.
// Expected writes and status come from a frame model of the protocol.
module tb_uart_boot_loader;

  localparam int unsigned CLK_FREQ = 2_000_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int          DIV      = 20;
  localparam int          MEM      = 1024;
  localparam logic [31:0] BASE     = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        skip_load = 1'b0;
  logic        mem_write;
  logic [2:0]  mem_option;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        core_hold;
  logic        busy;
  logic        error;

  uart_boot_loader #(
    .CLK_FREQ     (CLK_FREQ),
    .BAUD_RATE    (BAUD),
    .MEMORY_SIZE  (MEM),
    .BASE_ADDRESS (BASE)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx             (rx),
    .skip_load      (skip_load),
    .mem_write      (mem_write),
    .mem_option     (mem_option),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .core_hold      (core_hold),
    .busy           (busy),
    .error          (error)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  longint      cyc = 0;
  longint      last_wr_cyc = 0;
  longint      done_cyc = 0;
  logic        hold_prev = 1'b1;
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  logic [7:0]  payload[$];
  logic [7:0]  lead_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_write) begin
      got_addr.push_back(mem_address);
      got_data.push_back(mem_write_data);
      last_wr_cyc = cyc;
    end
    if (hold_prev && !core_hold) done_cyc = cyc;
    hold_prev = core_hold;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_mw"},    32'(mem_write), 32'd0);
    check({tag, "_opt"},   32'(mem_option), 32'd2);
    check({tag, "_addr"},  mem_address, BASE);
    check({tag, "_wdata"}, mem_write_data, 32'd0);
    check({tag, "_hold"},  32'(core_hold), 32'd1);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_err"},   32'(error), 32'd0);
  endtask

  task automatic fill(input int n);
    payload.delete();
    for (int i = 0; i < 4 * n; i++) payload.push_back(8'($urandom_range(0, 255)));
  endtask

  // Sends lead garbage + one frame and checks it against the frame model
  task automatic run_frame(input string tag, input int n, input logic [7:0] cs_delta);
    int          base;
    int          nexp;
    logic [7:0]  sum;
    logic [31:0] w;
    bit          too_big;
    bit          ok;
    base = got_data.size();
    foreach (lead_q[i]) send_byte(lead_q[i], 1'b1);
    lead_q.delete();
    send_byte(8'hA5, 1'b1);
    check({tag, "_busy_hdr"}, 32'(busy), 32'd1);
    check({tag, "_err_clr"}, 32'(error), 32'd0);
    send_byte(n[7:0], 1'b1);
    send_byte(n[15:8], 1'b1);
    too_big = (n * 4 > MEM);
    sum = 8'd0;
    ok = 1'b0;
    if (!too_big) begin
      for (int i = 0; i < 4 * n; i++) begin
        send_byte(payload[i], 1'b1);
        sum = sum + payload[i];
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(8'(sum + cs_delta), 1'b1);
      ok = (cs_delta == 8'd0);
`else
      ok = 1'b1;
`endif
    end
    repeat (4) @(negedge clk);
    nexp = too_big ? 0 : n;
    check({tag, "_nwr"}, 32'(got_data.size() - base), 32'(nexp));
    for (int i = 0; i < nexp && base + i < got_data.size(); i++) begin
      w = 32'(payload[4*i]) + (32'(payload[4*i+1]) << 8) +
          (32'(payload[4*i+2]) << 16) + (32'(payload[4*i+3]) << 24);
      check($sformatf("%s_addr%0d", tag, i), got_addr[base+i], BASE + 32'(4 * i));
      check($sformatf("%s_data%0d", tag, i), got_data[base+i], w);
    end
    check({tag, "_err"},  32'(error), 32'(!ok));
    check({tag, "_hold"}, 32'(core_hold), 32'(!ok));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    if (ok && n > 0) begin
`ifdef LOADER_CHECKSUM_EN
      check({tag, "_done_after_wr"}, 32'(done_cyc > last_wr_cyc), 32'd1);
`else
      check({tag, "_done_t"}, 32'(done_cyc - last_wr_cyc), 32'd1);
`endif
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    int          n;
    logic [7:0]  b;
    logic [7:0]  d;

    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);

    payload = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    lead_q = '{8'h00, 8'hFF};
    run_frame("dir", 2, 8'd0);

    do_reset();
`ifdef LOADER_CHECKSUM_EN
    run_frame("badcs", 2, 8'd1);
    fill(2);
    run_frame("recov", 2, 8'd0);
    do_reset();
`endif

    run_frame("big", 257, 8'd0);

    base = got_data.size();
    send_byte(8'hA5, 1'b1);
    check("stop_err_clr", 32'(error), 32'd0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b0);
    repeat (4) @(negedge clk);
    check("stop_err", 32'(error), 32'd1);
    check("stop_hold", 32'(core_hold), 32'd1);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_nwr", 32'(got_data.size() - base), 32'd0);

    do_reset();
    skip_load = 1'b1;
    @(posedge clk);
    #1;
    check("skip_hold", 32'(core_hold), 32'd0);
    @(negedge clk);
    skip_load = 1'b0;
    base = got_data.size();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'h5C, 1'b1);
    check("skip_nwr", 32'(got_data.size() - base), 32'd0);
    check("skip_hold2", 32'(core_hold), 32'd0);
    check("skip_busy", 32'(busy), 32'd0);

    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill(2);
    run_frame("after_rst", 2, 8'd0);

    do_reset();
    payload = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_frame("one", 1, 8'd0);

    for (int k = 0; k < 5; k++) begin
      do_reset();
      n = int'($urandom_range(0, 3));
      fill(n);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h00;
        lead_q.push_back(b);
      end
      d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      run_frame($sformatf("rnd%0d", k), n, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
